// File: rtl/apb_rr_scheduler.sv
// Round-robin arbiter sharing one APB master port among NREQ requesters.
// Runs SETUP/ACCESS, returns rdata/err, aborts stalled slaves on timeout.
module apb_rr_scheduler #(
  parameter int NREQ        = 4,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               Pclk,
  input  logic               Prst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_wr,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      rdata,
  output logic               err,
  output logic               tmo,
  output logic [AW-1:0]      Paddr,
  output logic               PSELx,
  output logic               P_en,
  output logic               P_WR,
  output logic [DW-1:0]      PWdata,
  input  logic [DW-1:0]      PRdata,
  input  logic               P_ready,
  input  logic               P_slverr
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            tmo_q, tmo_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic            pwr_q, pwr_d;
  logic            psel_q, psel_d;
  logic            pen_q, pen_d;

  logic            arb_hit;
  logic [PW-1:0]   arb_sel;
  logic [PW-1:0]   ptr_nxt;
  logic            last_wait;
  int              idx;

  // first set req bit at or above ptr, wrapping modulo NREQ
  always_comb begin
    arb_hit = 1'b0;
    arb_sel = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!arb_hit && req[idx]) begin
        arb_hit = 1'b1;
        arb_sel = PW'(idx);
      end
    end
  end

  assign ptr_nxt   = PW'((int'(sel_q) + 1) % NREQ);
  assign last_wait = (cnt_q == CW'(TIMEOUT_CYC - 1));

  // state register and all registered outputs
  always_ff @(posedge Pclk) begin
    if (Prst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwr_q    <= 1'b0;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwr_q    <= pwr_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
    end
  end

  // next-state: ready beats the timeout when both occur together
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arb_hit) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (P_ready || last_wait) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // output/datapath values to be registered at the coming edge
  always_comb begin
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    gnt_d    = '0;
    done_d   = '0;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    tmo_d    = 1'b0;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwr_d    = pwr_q;
    psel_d   = 1'b0;
    pen_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_hit) begin
          sel_d          = arb_sel;
          gnt_d[arb_sel] = 1'b1;
          paddr_d  = req_addr[int'(arb_sel)*AW +: AW];
          pwdata_d = req_wdata[int'(arb_sel)*DW +: DW];
          pwr_d    = req_wr[arb_sel];
          psel_d   = 1'b1;
        end
      end
      SETUP: begin
        psel_d = 1'b1;
        pen_d  = 1'b1;
        cnt_d  = '0;
      end
      ACCESS: begin
        if (P_ready) begin
          done_d[sel_q] = 1'b1;
          err_d         = P_slverr;
          if (!pwr_q) rdata_d = PRdata;
          ptr_d = ptr_nxt;
        end else if (last_wait) begin
          done_d[sel_q] = 1'b1;
          err_d         = 1'b1;
          tmo_d         = 1'b1;
          ptr_d         = ptr_nxt;
        end else begin
          psel_d = 1'b1;
          pen_d  = 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign rdata  = rdata_q;
  assign err    = err_q;
  assign tmo    = tmo_q;
  assign Paddr  = paddr_q;
  assign PSELx  = psel_q;
  assign P_en   = pen_q;
  assign P_WR   = pwr_q;
  assign PWdata = pwdata_q;

endmodule

// File: tb/tb_apb_rr_scheduler.sv
// Bench for apb_rr_scheduler: directed scenarios then random traffic,
// checked against a transaction-level round-robin model.
module tb_apb_rr_scheduler;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          Pclk = 1'b0;
  logic          Prst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  req_wr = '0;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]  gnt, done;
  logic [DW-1:0] rdata;
  logic          err, tmo;
  logic [AW-1:0] Paddr;
  logic          PSELx, P_en, P_WR;
  logic [DW-1:0] PWdata;
  logic [DW-1:0] PRdata = '0;
  logic          P_ready = 1'b0;
  logic          P_slverr = 1'b0;

  logic [AW-1:0] addr_a [N];
  logic [DW-1:0] wdata_a [N];

  int total = 0;
  int fails = 0;
  int ptr_m = 0;
  logic [DW-1:0] rdata_m = '0;

  apb_rr_scheduler #(
    .NREQ(N), .AW(AW), .DW(DW), .TIMEOUT_CYC(TMO)
  ) dut (
    .Pclk(Pclk), .Prst(Prst),
    .req(req), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .done(done),
    .rdata(rdata), .err(err), .tmo(tmo),
    .Paddr(Paddr), .PSELx(PSELx), .P_en(P_en),
    .P_WR(P_WR), .PWdata(PWdata),
    .PRdata(PRdata), .P_ready(P_ready),
    .P_slverr(P_slverr)
  );

  always #5 Pclk = ~Pclk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = addr_a[i];
      req_wdata[i*DW +: DW] = wdata_a[i];
    end
  end

  task automatic tick();
    @(posedge Pclk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // requester chosen by the round-robin rule, -1 if nobody asks
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, 64'(gnt), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_rdata"}, 64'(rdata), 0);
    chk({tag, "_err"}, 64'(err), 0);
    chk({tag, "_tmo"}, 64'(tmo), 0);
    chk({tag, "_paddr"}, 64'(Paddr), 0);
    chk({tag, "_psel"}, 64'(PSELx), 0);
    chk({tag, "_pen"}, 64'(P_en), 0);
    chk({tag, "_pwr"}, 64'(P_WR), 0);
    chk({tag, "_pwdata"}, 64'(PWdata), 0);
  endtask

  task automatic do_reset(input string tag);
    Prst = 1'b1;
    req  = '0;
    tick();
    tick();
    chk_zero(tag);
    Prst    = 1'b0;
    ptr_m   = 0;
    rdata_m = '0;
  endtask

  // One transfer starting from an IDLE cycle. w = cycles P_ready
  // stays low before rising; w >= TMO means the slave never answers.
  task automatic xfer(input int w, input logic slv,
                      input logic [DW-1:0] prd, input logic keep);
    int s;
    int i;
    logic last;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic wrb;
    logic err_e, tmo_e;
    s = pick(req, ptr_m);
    if (s < 0) begin
      tick();
      chk("idle_gnt", 64'(gnt), 0);
      chk("idle_psel", 64'(PSELx), 0);
      return;
    end
    a = addr_a[s];
    d = wdata_a[s];
    wrb = req_wr[s];
    tick();
    chk("setup_gnt", 64'(gnt), 64'(1 << s));
    chk("setup_psel", 64'(PSELx), 1);
    chk("setup_pen", 64'(P_en), 0);
    chk("setup_paddr", 64'(Paddr), 64'(a));
    chk("setup_pwdata", 64'(PWdata), 64'(d));
    chk("setup_pwr", 64'(P_WR), 64'(wrb));
    addr_a[s]  = $urandom;
    wdata_a[s] = $urandom;
    tick();
    i = 0;
    last = 1'b0;
    while (!last) begin
      chk("acc_psel", 64'(PSELx), 1);
      chk("acc_pen", 64'(P_en), 1);
      chk("acc_paddr", 64'(Paddr), 64'(a));
      chk("acc_pwdata", 64'(PWdata), 64'(d));
      chk("acc_pwr", 64'(P_WR), 64'(wrb));
      chk("acc_done", 64'(done), 0);
      P_ready  = (i == w);
      P_slverr = (i == w) ? slv : 1'($urandom);
      PRdata   = (i == w) ? prd : $urandom;
      last = (i == w) || (i == TMO - 1);
      i++;
      tick();
    end
    P_ready  = 1'b0;
    P_slverr = 1'b0;
    if (w < TMO) begin
      err_e = slv;
      tmo_e = 1'b0;
      if (!wrb) rdata_m = prd;
    end else begin
      err_e = 1'b1;
      tmo_e = 1'b1;
    end
    chk("done_vec", 64'(done), 64'(1 << s));
    chk("done_err", 64'(err), 64'(err_e));
    chk("done_tmo", 64'(tmo), 64'(tmo_e));
    chk("done_rdata", 64'(rdata), 64'(rdata_m));
    chk("done_psel", 64'(PSELx), 0);
    chk("done_gnt", 64'(gnt), 0);
    ptr_m = (s + 1) % N;
    if (!keep) req[s] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      addr_a[i]  = '0;
      wdata_a[i] = '0;
    end
    do_reset("rst0");

    // single zero-wait read from requester 0
    addr_a[0] = 32'hA000;
    req_wr    = 4'b0000;
    req       = 4'b0001;
    xfer(0, 1'b0, 32'h1234, 1'b0);
    chk("rd0_rdata", 64'(rdata), 64'h1234);

    // write with three wait states from requester 2
    addr_a[2]  = 32'hA004;
    wdata_a[2] = 32'hDEADBEEF;
    req_wr     = 4'b0100;
    req        = 4'b0100;
    xfer(3, 1'b0, 32'h5555, 1'b0);

    // all requesters asking continuously, zero-wait slave
    do_reset("rst1");
    req_wr = 4'b0000;
    req    = 4'b1111;
    for (int k = 0; k < 6; k++)
      xfer(0, 1'b0, $urandom, 1'b1);

    // ready on the final allowed cycle, then a full timeout
    xfer(TMO - 1, 1'b0, 32'hCAFE0001, 1'b1);
    xfer(TMO, 1'b0, 32'hBAD0BAD0, 1'b1);
    chk("tmo_rdata", 64'(rdata), 64'hCAFE0001);
    xfer(0, 1'b0, 32'h0BEEF0, 1'b1);

    // slave error, then a clean transfer
    xfer(0, 1'b1, 32'h77, 1'b1);
    xfer(1, 1'b0, 32'h88, 1'b1);
    req = '0;
    tick();

    // reset during ACCESS of requester 1 abandons the transfer
    req = 4'b0010;
    tick();
    chk("mid_gnt", 64'(gnt), 64'b0010);
    tick();
    chk("mid_pen", 64'(P_en), 1);
    Prst = 1'b1;
    tick();
    chk_zero("mid_rst");
    Prst    = 1'b0;
    ptr_m   = 0;
    rdata_m = '0;
    req     = 4'b0011;
    xfer(0, 1'b0, 32'h42, 1'b0);
    chk("post_ptr", 64'(ptr_m), 1);

    // random traffic; ungranted requesters may also withdraw
    for (int t = 0; t < 60; t++) begin
      for (int j = 0; j < N; j++) begin
        if (!req[j] && ($urandom_range(0, 2) == 0)) begin
          req[j]     = 1'b1;
          req_wr[j]  = 1'($urandom);
          addr_a[j]  = $urandom;
          wdata_a[j] = $urandom;
        end else if (req[j] && ($urandom_range(0, 7) == 0)) begin
          req[j] = 1'b0;
        end
      end
      xfer(int'($urandom_range(0, TMO + 2)),
           1'($urandom_range(0, 3) == 0),
           $urandom, 1'b0);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/apb_rr_scheduler.md
Name: apb_rr_scheduler

Overview:
- Round-robin scheduler that shares one APB master port between NREQ local requesters.
- Latches one requester's command, runs the APB SETUP/ACCESS sequence and returns read data and error status to the granted requester.
- Adds a wait-state timeout so a stalled slave cannot hang the bus.
- Sits between the incrementor/requester logic and the APB slave fabric.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 32, APB address width
DW, 32, APB data width
TIMEOUT_CYC, 16, maximum ACCESS cycles with P_ready low before the transfer is aborted (>=2)

Ports:
Pclk  input  1  APB clock; the only clock
Prst  input  1  synchronous, active-high reset
req  input  NREQ  per-requester transfer request; held until that requester's done
req_wr  input  NREQ  1 = write, 0 = read; valid while req is high
req_addr  input  NREQ*AW  packed addresses; requester i at [i*AW +: AW]
req_wdata  input  NREQ*DW  packed write data; same packing
gnt  output  NREQ  one-hot; pulses 1 cycle when a command is latched
done  output  NREQ  one-hot; pulses 1 cycle when the transfer completes
rdata  output  DW  read data; valid in the done cycle
err  output  1  slave error or timeout; valid in the done cycle
tmo  output  1  timeout abort; valid in the done cycle
Paddr  output  AW  APB address
PSELx  output  1  APB select
P_en  output  1  APB enable
P_WR  output  1  APB write
PWdata  output  DW  APB write data
PRdata  input  DW  APB read data
P_ready  input  1  slave ready, active high
P_slverr  input  1  slave error; sampled only when P_ready is high in ACCESS

Behaviour:
- Reset, evaluated at a Pclk edge with Prst=1:
  - state=IDLE, round-robin pointer=0, wait counter=0.
  - All outputs 0: gnt, done, rdata, err, tmo, Paddr, PSELx, P_en, P_WR, PWdata.
  - A reset asserted mid-transfer abandons the transfer: PSELx/P_en drop at that edge and no done is issued.
- FSM, registered outputs:
  - IDLE: if any req bit is set, select the first set bit searching from ptr upward with wrap modulo NREQ.
    - Latch its addr, wdata and wr into the Paddr/PWdata/P_WR registers.
    - Pulse gnt[sel], go to SETUP.
    - If no req, stay in IDLE; PSELx=P_en=0 and Paddr/PWdata/P_WR hold their last values.
  - SETUP: PSELx=1, P_en=0. Always go to ACCESS next cycle; clear the wait counter.
  - ACCESS: PSELx=1, P_en=1; Paddr, PWdata, P_WR stable throughout.
    - P_ready=1: complete.
      - Pulse done[sel]; err=P_slverr; tmo=0.
      - rdata=PRdata on a read; rdata holds its previous value on a write.
      - ptr=(sel+1) mod NREQ; go to IDLE.
    - P_ready=0 and counter==TIMEOUT_CYC-1: abort.
      - Pulse done[sel]; err=1; tmo=1; rdata unchanged.
      - Advance ptr as for completion; go to IDLE.
    - Otherwise increment the counter and stay in ACCESS.
- Timing:
  - Minimum transfer: request seen in IDLE, then SETUP, ACCESS, and done one cycle after P_ready is sampled high.
  - Back-to-back transfers have one IDLE cycle between them: gnt occurs at the IDLE→SETUP edge.
- Requests:
  - A requester must keep req high until its done.
  - req changes for the active requester during a transfer are ignored.
  - A requester whose req drops before being granted is skipped.
- Fairness: after a granted requester completes, it has lowest priority. With all NREQ requesting continuously, grants rotate 0,1,2,3,0,…
- Simultaneous events:
  - A completion and new requests in the same cycle: the new arbitration happens in the following IDLE cycle using the updated ptr.
  - P_ready and the timeout condition in the same cycle: P_ready wins, normal completion.
- err, tmo and done are single-cycle pulses, 0 otherwise. rdata holds its value between reads.

Test Plan:
- Reset then single read: req=4'b0001 addr0=0xA000, slave returns 0x1234 with P_ready high on the first ACCESS cycle → SETUP 1 cycle, ACCESS 1 cycle, done[0] pulse, rdata=0x1234, err=0.
- Write with 3 wait states: req[2] wr=1 addr=0xA004 wdata=0xDEADBEEF → PSELx/P_en/Paddr/PWdata stable for 4 ACCESS cycles, done[2] pulse, err=0.
- All four requesting continuously with zero-wait slave → gnt order 0,1,2,3,0,1; one IDLE cycle between transfers.
- Slave holds P_ready=0 → after exactly 16 ACCESS cycles: done pulse, err=1, tmo=1, rdata unchanged, next requester granted.
- Read with P_slverr=1 at completion → err=1, tmo=0, done pulse; the next transfer's err=0.
- Prst=1 asserted during ACCESS of requester 1 → next edge PSELx=P_en=0 and all outputs 0, no done; after release with req=4'b0011, requester 0 is granted first (ptr=0).
